mem_access_stage: RTL and testbench

- Memory stage of the 16-bit pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Performs data-memory loads and stores over a req/ack handshake with variable latency. Stalls upstream while an access is outstanding.
- Presents write-back fields plus a one-cycle capture enable (OAdvance) that drives the MEM/WB register's write-enable input.
- Non-memory instructions pass through combinationally with zero added latency.

---
 rtl/pipe_pkg.sv | 6 +
 rtl/mem_access_stage_if.sv | 11 +
 rtl/mem_wait_timer.sv | 19 +
 rtl/mem_access_stage.sv | 110 +++++++++++
 tb/tb_mem_access_stage.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the 16-bit pipeline memory stage
package pipe_pkg;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] DEAD_VALUE_DEF = 16'hDEAD;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: req/ack data-memory bus between the memory stage and data memory
interface mem_access_stage_if;
    logic                          MemReq;
    logic                          MemWe;
    logic [pipe_pkg::WORD_W-2:0]   MemAddr;
    logic [pipe_pkg::WORD_W-1:0]   MemWdata;
    logic [pipe_pkg::WORD_W-1:0]   MemRdata;
    logic                          MemAck;
    modport master (output MemReq, MemWe, MemAddr, MemWdata, input MemRdata, MemAck);
    modport slave (input MemReq, MemWe, MemAddr, MemWdata, output MemRdata, MemAck);
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting for a memory ack; flags the last allowed cycle
module mem_wait_timer #(
    parameter int LIMIT = 64
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    // clear on a new access, otherwise count each waited cycle
    always_ff @(posedge CLK) begin
        if (Reset || clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    assign last = cnt == W'(LIMIT - 1);
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage issuing loads/stores over a variable-latency req/ack bus
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int                MEM_TIMEOUT = 64,
    parameter logic [WORD_W-1:0] DEAD_VALUE  = DEAD_VALUE_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    mem_access_stage_if.master mem,
    input  logic              IValid,
    input  logic              IMemRead,
    input  logic              IMemWrite,
    input  logic              IRegWrite,
    input  logic              IRegStore,
    input  logic [WORD_W-1:0] IALUResult,
    input  logic [WORD_W-1:0] IStoreData,
    input  logic [WORD_W-1:0] IRd,
    output logic              ORegWrite,
    output logic              ORegStore,
    output logic [WORD_W-1:0] OALUResult,
    output logic [WORD_W-1:0] OStoreMem,
    output logic [WORD_W-1:0] ORd,
    output logic              OAdvance,
    output logic              OStall,
    output logic              OMisaligned,
    output logic              OTimeout
);
    state_t state, state_nx;
    logic memop, idle, accept, misalign, in_access, last;
    logic rw_q, rs_q;
    logic [WORD_W-1:0] alu_q, rd_q, load_q;

    assign idle      = state == IDLE;
    assign in_access = state == ACCESS;
    assign memop     = IValid & (IMemRead | IMemWrite);
    assign accept    = idle & memop & ~IALUResult[0];
    assign misalign  = idle & memop & IALUResult[0];

    mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .CLK   (CLK),
        .Reset (Reset),
        .clr   (accept),
        .en    (in_access & ~mem.MemAck & ~last),
        .last  (last)
    );

    // state register
    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else state <= state_nx;
    end

    // next state: accept aligned memops, finish on ack or timeout, always retire through DONE
    always_comb begin
        state_nx = idle ? (accept ? ACCESS : IDLE)
                 : in_access ? ((mem.MemAck | last) ? DONE : ACCESS)
                 : IDLE;
    end

    // stage outputs: passthrough while idle, latched fields once the access has retired
    always_comb begin
        OAdvance   = idle ? ~accept : (state == DONE);
        OStall     = accept | in_access;
        ORegWrite  = idle ? IValid & IRegWrite & ~misalign : rw_q;
        ORegStore  = idle ? IRegStore : rs_q;
        OALUResult = idle ? IALUResult : alu_q;
        ORd        = idle ? IRd : rd_q;
        OStoreMem  = (state == DONE) ? load_q : '0;
    end

    // bus request, latched instruction fields, load data and sticky error flags
    always_ff @(posedge CLK) begin
        if (Reset) begin
            mem.MemReq   <= 1'b0;
            mem.MemWe    <= 1'b0;
            mem.MemAddr  <= '0;
            mem.MemWdata <= '0;
            rw_q         <= 1'b0;
            rs_q         <= 1'b0;
            alu_q        <= '0;
            rd_q         <= '0;
            load_q       <= '0;
            OMisaligned  <= 1'b0;
            OTimeout     <= 1'b0;
        end else begin
            if (accept) begin
                rw_q         <= IRegWrite;
                rs_q         <= IRegStore;
                alu_q        <= IALUResult;
                rd_q         <= IRd;
                mem.MemAddr  <= IALUResult[WORD_W-1:1];
                mem.MemWdata <= IStoreData;
                mem.MemReq   <= 1'b1;
                mem.MemWe    <= IMemWrite;
            end else if (in_access && mem.MemAck) begin
                mem.MemReq <= 1'b0;
                mem.MemWe  <= 1'b0;
                load_q     <= mem.MemWe ? '0 : mem.MemRdata;
            end else if (in_access && last) begin
                mem.MemReq <= 1'b0;
                mem.MemWe  <= 1'b0;
                load_q     <= DEAD_VALUE;
                rw_q       <= 1'b0;
                OTimeout   <= 1'b1;
            end
            if (misalign) OMisaligned <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized transaction checks of the memory stage
module tb_mem_access_stage;
    import pipe_pkg::*;
    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        IValid = 1'b0, IMemRead = 1'b0, IMemWrite = 1'b0, IRegWrite = 1'b0, IRegStore = 1'b0;
    logic [15:0] IALUResult = '0, IStoreData = '0, IRd = '0;
    logic        ORegWrite, ORegStore, OAdvance, OStall, OMisaligned, OTimeout;
    logic [15:0] OALUResult, OStoreMem, ORd;
    int          tests = 0, fails = 0;
    logic        exp_mis = 1'b0, exp_to = 1'b0;

    mem_access_stage_if mem();

    mem_access_stage #(.MEM_TIMEOUT(TO)) dut (
        .CLK(CLK), .Reset(Reset), .mem(mem),
        .IValid(IValid), .IMemRead(IMemRead), .IMemWrite(IMemWrite),
        .IRegWrite(IRegWrite), .IRegStore(IRegStore), .IALUResult(IALUResult),
        .IStoreData(IStoreData), .IRd(IRd),
        .ORegWrite(ORegWrite), .ORegStore(ORegStore), .OALUResult(OALUResult),
        .OStoreMem(OStoreMem), .ORd(ORd), .OAdvance(OAdvance), .OStall(OStall),
        .OMisaligned(OMisaligned), .OTimeout(OTimeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // one instruction through the stage; dly = ack cycle index within ACCESS, dly >= TO means never
    task automatic run_op(input logic v, rdf, wrf, rw, rs, input logic [15:0] alu, sd, rd,
                          input int dly, input logic [15:0] rdata);
        logic memop, mis, acked;
        logic [15:0] exp_ld;
        IValid = v; IMemRead = rdf; IMemWrite = wrf; IRegWrite = rw; IRegStore = rs;
        IALUResult = alu; IStoreData = sd; IRd = rd;
        mem.MemAck = 1'b0;
        memop = v & (rdf | wrf);
        mis = alu[0];
        @(negedge CLK);
        if (!memop || mis) begin
            chk1("pass_adv", OAdvance, 1'b1);
            chk1("pass_stall", OStall, 1'b0);
            chk1("pass_rw", ORegWrite, v & rw & ~(memop & mis));
            chk1("pass_rs", ORegStore, rs);
            chk16("pass_alu", OALUResult, alu);
            chk16("pass_rd", ORd, rd);
            chk16("pass_ld", OStoreMem, 16'h0);
            chk1("pass_req", mem.MemReq, 1'b0);
            if (memop) exp_mis = 1'b1;
            tick();
            chk1("mis_flag", OMisaligned, exp_mis);
            chk1("pass_req_after", mem.MemReq, 1'b0);
            return;
        end
        chk1("acc_stall", OStall, 1'b1);
        chk1("acc_adv", OAdvance, 1'b0);
        chk1("acc_req0", mem.MemReq, 1'b0);
        for (int k = 0; ; k++) begin
            tick();
            mem.MemAck = (k == dly);
            mem.MemRdata = (k == dly) ? rdata : 16'($urandom);
            @(negedge CLK);
            chk1("req", mem.MemReq, 1'b1);
            chk1("we", mem.MemWe, wrf);
            chk16("addr", {1'b0, mem.MemAddr}, {1'b0, alu[15:1]});
            chk16("wdata", mem.MemWdata, sd);
            chk1("wait_stall", OStall, 1'b1);
            chk1("wait_adv", OAdvance, 1'b0);
            if (k == dly || k == TO - 1) break;
        end
        acked = dly < TO;
        exp_ld = !acked ? 16'hDEAD : wrf ? 16'h0 : rdata;
        if (!acked) exp_to = 1'b1;
        tick();
        mem.MemAck = 1'($urandom);
        IValid = 1'($urandom); IMemRead = 1'($urandom); IMemWrite = 1'($urandom);
        IRegWrite = 1'($urandom); IRegStore = 1'($urandom);
        IALUResult = 16'($urandom); IRd = 16'($urandom);
        @(negedge CLK);
        chk1("done_adv", OAdvance, 1'b1);
        chk1("done_stall", OStall, 1'b0);
        chk1("done_req", mem.MemReq, 1'b0);
        chk16("done_ld", OStoreMem, exp_ld);
        chk1("done_rw", ORegWrite, acked & rw);
        chk1("done_rs", ORegStore, rs);
        chk16("done_alu", OALUResult, alu);
        chk16("done_rd", ORd, rd);
        chk1("done_to", OTimeout, exp_to);
        tick();
        mem.MemAck = 1'b0;
        IValid = 1'b0;
    endtask

    initial begin
        mem.MemAck = 1'b0;
        mem.MemRdata = '0;
        tick();
        tick();
        Reset = 1'b0;
        @(negedge CLK);
        chk1("rst_req", mem.MemReq, 1'b0);
        chk1("rst_we", mem.MemWe, 1'b0);
        chk16("rst_addr", {1'b0, mem.MemAddr}, 16'h0);
        chk16("rst_wdata", mem.MemWdata, 16'h0);
        chk1("rst_mis", OMisaligned, 1'b0);
        chk1("rst_to", OTimeout, 1'b0);
        chk1("rst_adv", OAdvance, 1'b1);
        chk1("rst_rw", ORegWrite, 1'b0);
        tick();
        run_op(1, 0, 0, 1, 0, 16'h1234, 16'h0, 16'h0003, 0, 16'h0);
        run_op(1, 1, 0, 1, 1, 16'h0040, 16'h0, 16'h0005, 2, 16'hBEEF);
        run_op(1, 0, 1, 0, 0, 16'h0010, 16'h5A5A, 16'h0001, 0, 16'h0);
        run_op(1, 1, 1, 1, 1, 16'h0022, 16'hA5A5, 16'h0002, 1, 16'h7777);
        run_op(1, 1, 0, 1, 1, 16'h0100, 16'h0, 16'h0004, TO - 1, 16'h1357);
        run_op(1, 1, 0, 1, 1, 16'h0003, 16'h0, 16'h0006, 0, 16'h0);
        run_op(1, 1, 0, 1, 1, 16'h0200, 16'h0, 16'h0007, TO + 5, 16'h0);
        // reset during the second ACCESS cycle
        IValid = 1; IMemRead = 1; IMemWrite = 0; IRegWrite = 1; IALUResult = 16'h0080;
        @(negedge CLK);
        chk1("rst_mid_stall", OStall, 1'b1);
        tick();
        tick();
        chk1("rst_mid_req", mem.MemReq, 1'b1);
        Reset = 1'b1;
        IValid = 1'b0;
        tick();
        Reset = 1'b0;
        exp_mis = 1'b0;
        exp_to = 1'b0;
        @(negedge CLK);
        chk1("rst_mid_req0", mem.MemReq, 1'b0);
        chk1("rst_mid_stall0", OStall, 1'b0);
        chk1("rst_mid_mis", OMisaligned, 1'b0);
        chk1("rst_mid_to", OTimeout, 1'b0);
        chk16("rst_mid_ld", OStoreMem, 16'h0);
        tick();
        mem.MemAck = 1'b1;
        mem.MemRdata = 16'hFACE;
        tick();
        mem.MemAck = 1'b0;
        @(negedge CLK);
        chk1("late_ack_req", mem.MemReq, 1'b0);
        chk1("late_ack_adv", OAdvance, 1'b1);
        chk16("late_ack_ld", OStoreMem, 16'h0);
        tick();
        run_op(1, 1, 0, 1, 0, 16'h0300, 16'h0, 16'h0009, 1, 16'hC0DE);
        for (int i = 0; i < 60; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
            run_op(1'($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), a, 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, TO + 1)), 16'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
